jt12_slot_wr: RTL and testbench

- Write-merge stage that sits directly upstream of the 24-slot per-operator shift ring.
- Drives the ring input: it either recirculates the ring's last stage or substitutes a pending register write at the moment the target slot passes.
- Owns the slot counter that defines slot order for the ring, so CPU-side register writes land in the correct operator/channel slot without a RAM.

---
 rtl/jt12_slot_wr.sv | 142 ++++++++++++++
 tb/tb_jt12_slot_wr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_slot_wr.sv
// -----------------------------------------------------------------------------
// jt12_slot_wr
//   Write-merge stage in front of the 24-slot per-operator shift ring. Owns the
//   slot counter that defines ring order, and substitutes a pending register
//   write into the ring input at the moment its target slot passes. Otherwise
//   the ring's last stage is recirculated unchanged.
//
//   Slot order: slot = grp*6 + chi
//     chi 0..5 <- wr_ch 0,1,2,4,5,6   (wr_ch 3 and 7 are invalid)
//     grp 0..3 <- operator S1,S3,S2,S4 (wr_op 0=S1, 1=S2, 2=S3, 3=S4)
//
//   Optional build macro: JT12_SLOT_WR_INITCLR_EN
//     When defined, reset release starts a one-revolution sweep that forces
//     ring_out to zero for 24 clk_en edges (slots 0..23). wr_busy is high for
//     the whole sweep and no wr_done is produced at its end.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   clk_en     ring/slot counter advance enable
//   wr_req     write request, sampled every clk
//   wr_ch      target channel (register encoding)
//   wr_op      target operator
//   wr_data    value to store
//   wr_busy    write pending (or init sweep running); requests ignored
//   wr_done    one-clk pulse on commit or rejection
//   wr_err     qualifies wr_done: 1 = rejected for invalid channel
//   ring_in    ring last stage, fed back
//   ring_out   value entering ring stage 1 (combinational from ring_in)
//   slot_cnt   slot entering the ring on the next clk_en edge, 0..23
//   zero       high while slot_cnt == 0
//
// Handshake: wr_req/wr_busy behave as valid/ready with ready = ~wr_busy. A
// request is taken on any clk edge where wr_req=1 and wr_busy=0; it is finished
// by the wr_done pulse. While wr_busy=1 the request is simply not taken, so a
// requester keeps wr_req high until its wr_done (or err) arrives.
// -----------------------------------------------------------------------------
module jt12_slot_wr #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             wr_req,
  input  logic [2:0]       wr_ch,
  input  logic [1:0]       wr_op,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_done,
  output logic             wr_err,
  input  logic [width-1:0] ring_in,
  output logic [width-1:0] ring_out,
  output logic [4:0]       slot_cnt,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

`ifdef JT12_SLOT_WR_INITCLR_EN
  localparam state_t RST_STATE = ST_SWEEP;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  // Exposed for checkers bound by hierarchy.
  state_t           state;
  logic [4:0]       target_q;
  logic [width-1:0] data_q;
  logic             hit;
  logic             ch_valid;
  logic [4:0]       target_d;

  // Channel 3 and 7 have no slot.
  assign ch_valid = (wr_ch[1:0] != 2'b11);

  // chi: channels 4..6 fold down by one to 3..5.
  // grp: operator bits swapped, giving S1,S3,S2,S4 order.
  // grp*6 = grp*4 + grp*2.
  always_comb begin
    logic [2:0] chi;
    logic [1:0] grp;
    chi      = wr_ch[2] ? (wr_ch - 3'd1) : wr_ch;
    grp      = {wr_op[0], wr_op[1]};
    target_d = {1'b0, grp, 2'b00} + {2'b00, grp, 1'b0} + {2'b00, chi};
  end

  assign hit      = (state == ST_BUSY) && (slot_cnt == target_q);
  assign wr_busy  = (state != ST_IDLE);
  assign zero     = (slot_cnt == 5'd0);
  assign ring_out = (state == ST_SWEEP) ? '0 :
                    hit                 ? data_q : ring_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      slot_cnt <= 5'd0;
      target_q <= 5'd0;
      data_q   <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;

      if (clk_en)
        slot_cnt <= (slot_cnt == 5'd23) ? 5'd0 : slot_cnt + 5'd1;

      case (state)
        ST_IDLE: begin
          if (wr_req) begin
            if (ch_valid) begin
              target_q <= target_d;
              data_q   <= wr_data;
              state    <= ST_BUSY;
            end else begin
              wr_done <= 1'b1;
              wr_err  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // hit can sit high with clk_en low; the write lands only when the
          // ring actually shifts.
          if (hit && clk_en) begin
            state   <= ST_IDLE;
            wr_done <= 1'b1;
          end
        end
        ST_SWEEP: begin
          // Sweep began at slot 0, so the edge leaving slot 23 ends it.
          if (clk_en && (slot_cnt == 5'd23))
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_slot_wr.sv
// -----------------------------------------------------------------------------
// tb_jt12_slot_wr
//   Randomised and directed stimulus for jt12_slot_wr, checked every cycle
//   against a slot-level reference model (table lookup of channel/operator to
//   slot, integer slot counter, single pending-write record). Committed data is
//   also checked through an expected queue.
// -----------------------------------------------------------------------------
module tb_jt12_slot_wr;

  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_en = 1'b0;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_ch = 3'd0;
  logic [1:0]   wr_op = 2'd0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] ring_in = '0;
  logic         wr_busy, wr_done, wr_err, zero;
  logic [W-1:0] ring_out;
  logic [4:0]   slot_cnt;

  always #5 clk = ~clk;

  jt12_slot_wr #(.width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .wr_req   (wr_req),
    .wr_ch    (wr_ch),
    .wr_op    (wr_op),
    .wr_data  (wr_data),
    .wr_busy  (wr_busy),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .ring_in  (ring_in),
    .ring_out (ring_out),
    .slot_cnt (slot_cnt),
    .zero     (zero)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int chi_tbl[8] = '{0, 1, 2, -1, 3, 4, 5, -1};
  int grp_tbl[4] = '{0, 2, 1, 3};  // S1,S2,S3,S4 -> group position

`ifdef JT12_SLOT_WR_INITCLR_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  int           m_slot;
  bit           m_busy, m_sweep, m_done, m_err;
  int           m_tgt;
  logic [W-1:0] m_data;
  int           n_commits;

  function automatic void model_reset();
    m_slot  = 0;
    m_busy  = 0;
    m_sweep = SWEEP_EN;
    m_done  = 0;
    m_err   = 0;
    m_tgt   = 0;
    m_data  = '0;
    exp_q.delete();
  endfunction

  // One clock: new ring_in, compare at negedge, advance model for the posedge.
  task automatic cycle();
    bit           hit;
    logic [W-1:0] exp_ring;
    ring_in = W'($urandom);
    @(negedge clk);
    hit      = m_busy && (m_slot == m_tgt);
    exp_ring = m_sweep ? '0 : (hit ? m_data : ring_in);
    check("slot_cnt", 32'(slot_cnt), 32'(m_slot));
    check("zero",     32'(zero),     32'(m_slot == 0));
    check("wr_busy",  32'(wr_busy),  32'(m_busy | m_sweep));
    check("wr_done",  32'(wr_done),  32'(m_done));
    check("wr_err",   32'(wr_err),   32'(m_err));
    check("ring_out", 32'(ring_out), 32'(exp_ring));

    m_done = 0;
    m_err  = 0;
    if (m_sweep) begin
      if (clk_en && m_slot == 23) m_sweep = 0;
    end else if (m_busy) begin
      if (hit && clk_en) begin
        m_busy = 0;
        m_done = 1;
        n_commits++;
        if (exp_q.size() == 0) check("commit_unexpected", 32'd1, 32'd0);
        else check("commit_data", 32'(ring_out), 32'(exp_q.pop_front()));
      end
    end else if (wr_req) begin
      if (chi_tbl[wr_ch] >= 0) begin
        m_busy = 1;
        m_tgt  = grp_tbl[wr_op] * 6 + chi_tbl[wr_ch];
        m_data = wr_data;
        exp_q.push_back(wr_data);
      end else begin
        m_done = 1;
        m_err  = 1;
      end
    end
    if (clk_en) m_slot = (m_slot + 1) % 24;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance with clk_en=1 until the model is idle at slot s (bounded).
  task automatic goto_slot(input int s);
    int k;
    clk_en = 1'b1;
    wr_req = 1'b0;
    k = 0;
    while ((m_slot != s || m_busy || m_sweep) && k < 100) begin
      cycle();
      k++;
    end
    if (k >= 100) check("goto_slot_timeout", 32'd1, 32'd0);
  endtask

  task automatic request(input logic [2:0] ch, input logic [1:0] op, input logic [W-1:0] d);
    wr_req  = 1'b1;
    wr_ch   = ch;
    wr_op   = op;
    wr_data = d;
    cycle();
    wr_req  = 1'b0;
    wr_data = W'($urandom);  // must not affect the pending write
  endtask

  // Assert async reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_busy",  32'(wr_busy),  32'(SWEEP_EN));
    check("rst_done",  32'(wr_done),  32'd0);
    check("rst_err",   32'(wr_err),   32'd0);
    check("rst_slot",  32'(slot_cnt), 32'd0);
    check("rst_zero",  32'(zero),     32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_commits = 0;
    model_reset();
    #3;
    check("init_slot", 32'(slot_cnt), 32'd0);
    check("init_zero", 32'(zero),     32'd1);
    check("init_busy", 32'(wr_busy),  32'(SWEEP_EN));
    check("init_done", 32'(wr_done),  32'd0);
    check("init_err",  32'(wr_err),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Free run: slot stepping, recirculation (or sweep when enabled).
    clk_en = 1'b1;
    run(30);

    // Slot 9 target (ch4, S3) requested at slot 3.
    goto_slot(3);
    request(3'd4, 2'd2, 5'h15);
    run(30);

    // Target equals the slot at acceptance: full revolution (ch1, S3 -> 7).
    goto_slot(7);
    request(3'd1, 2'd2, W'($urandom));
    run(30);

    // Invalid channel: immediate error, ring untouched for a revolution.
    goto_slot(2);
    request(3'd3, 2'd0, 5'h1F);
    run(26);
    request(3'd7, 2'd3, W'($urandom));
    run(3);

    // Second request while busy is ignored; held request is taken later.
    goto_slot(0);
    request(3'd6, 2'd3, 5'h0A);
    wr_req  = 1'b1;
    wr_ch   = 3'd0;
    wr_op   = 2'd1;
    wr_data = 5'h11;
    run(60);
    wr_req = 1'b0;
    run(2);

    // clk_en gating while hit is high.
    goto_slot(1);
    request(3'd2, 2'd0, 5'h07);  // slot 2
    begin
      int k = 0;
      while (!(m_busy && m_slot == m_tgt) && k < 50) begin
        cycle();
        k++;
      end
      if (k >= 50) check("hit_timeout", 32'd1, 32'd0);
    end
    clk_en = 1'b0;
    run(10);
    clk_en = 1'b1;
    run(3);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      clk_en  = ($urandom_range(0, 9) < 7);
      wr_req  = ($urandom_range(0, 4) == 0);
      wr_ch   = 3'($urandom_range(0, 7));
      wr_op   = 2'($urandom_range(0, 3));
      wr_data = W'($urandom);
      cycle();
    end
    wr_req = 1'b0;
    clk_en = 1'b1;

    // Async reset with a write pending.
    goto_slot(5);
    request(3'd5, 2'd1, 5'h1C);
    run(3);
    async_reset();
    run(30);

    check("commits_seen", 32'(n_commits > 20), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
